imem_loader: RTL and testbench

- Boot-time writer for the 64-word instruction memory that the CPU fetch path reads.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes each word to the word-aligned byte address the fetch side decodes with address[7:2].
- Holds the CPU in reset until the image is fully written, then releases it.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/imem_word_pack.sv | 36 +++
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction width, memory depth, loader states.
package cpu_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned IMEM_DEPTH = 64;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BCNT_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

    // Shift one stream byte into a partially assembled instruction word.
    function automatic logic [INST_W-1:0] pack_byte(
        input logic [INST_W-1:0] word,
        input logic [BYTE_W-1:0] data,
        input logic              big_endian
    );
        if (big_endian) begin
            return {word[INST_W-BYTE_W-1:0], data};
        end
        return {data, word[INST_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/imem_word_pack.sv
// Byte-to-word assembler: shift register, 2-bit byte counter and a one-cycle full flag.
module imem_word_pack
    import cpu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [BYTE_W-1:0] data,
    output logic [INST_W-1:0] word,
    output logic [BCNT_W-1:0] cnt,
    output logic              full
);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(3);

    // full pulses for exactly the cycle after the fourth byte lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            full <= shift && (cnt == LAST_BYTE);
            if (clr) begin
                cnt <= '0;
            end else if (shift) begin
                word <= pack_byte(word, data, BIG_ENDIAN);
                cnt  <= cnt + BCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes a length-prefixed byte image into instruction memory, holding the CPU meanwhile.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = IMEM_DEPTH,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [INST_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = BYTE_W + 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(3);

    ldr_state_t        state, state_nxt;
    logic [BYTE_W-1:0] n_words, n_words_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [INST_W-1:0] mem_addr_nxt;
    logic              in_ready_nxt, busy_nxt, done_nxt, err_nxt, cpu_hold_nxt;
    logic              xfer, last_word, bad_len;
    logic              pack_clr, pack_shift;
    logic [INST_W-1:0] pack_word;
    logic [BCNT_W-1:0] pack_cnt;
    logic              pack_full;
`ifdef IMEM_LOADER_CSUM_EN
    logic [BYTE_W-1:0] csum, csum_nxt;
`endif

    assign xfer      = in_valid && in_ready;
    assign last_word = (CW'(idx) + CW'(1)) == CW'(n_words);
    assign bad_len   = (in_data == '0) || (CW'(in_data) > CW'(DEPTH));

    imem_word_pack #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_pack (
        .clk   (clk),
        .rst   (rst),
        .clr   (pack_clr),
        .shift (pack_shift),
        .data  (in_data),
        .word  (pack_word),
        .cnt   (pack_cnt),
        .full  (pack_full)
    );

    // The packer's full pulse coincides with the WRITE state, so it is the write strobe.
    assign mem_we    = pack_full;
    assign mem_wdata = pack_word;

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt    = state;
        n_words_nxt  = n_words;
        idx_nxt      = idx;
        mem_addr_nxt = mem_addr;
        pack_clr     = 1'b0;
        pack_shift   = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_nxt     = csum;
`endif

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    if (bad_len) begin
                        state_nxt = ST_ERR;
                    end else begin
                        n_words_nxt = in_data;
                        idx_nxt     = '0;
                        pack_clr    = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_nxt    = '0;
`endif
                        state_nxt   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    pack_shift = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_nxt   = csum ^ in_data;
`endif
                    if (pack_cnt == LAST_BYTE) begin
                        mem_addr_nxt = INST_W'({idx, 2'b00});
                        state_nxt    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // idx holds at DEPTH-1 on the final word rather than wrapping.
                if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_DONE;
`endif
                end else begin
                    idx_nxt   = idx + IW'(1);
                    state_nxt = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    state_nxt = (in_data == csum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt = ST_LEN;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt == ST_LEN) || (state_nxt == ST_DATA);
        busy_nxt     = (state_nxt == ST_LEN) || (state_nxt == ST_DATA) ||
                       (state_nxt == ST_WRITE);
`ifdef IMEM_LOADER_CSUM_EN
        in_ready_nxt = in_ready_nxt || (state_nxt == ST_CSUM);
        busy_nxt     = busy_nxt || (state_nxt == ST_CSUM);
`endif
        done_nxt     = (state_nxt == ST_DONE);
        err_nxt      = (state_nxt == ST_ERR);
        cpu_hold_nxt = (state_nxt != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            n_words  <= '0;
            idx      <= '0;
            mem_addr <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state    <= state_nxt;
            n_words  <= n_words_nxt;
            idx      <= idx_nxt;
            mem_addr <= mem_addr_nxt;
            in_ready <= in_ready_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            cpu_hold <= cpu_hold_nxt;
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    // Running XOR of data bytes, compared against the trailing checksum byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else begin
            csum <= csum_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; covers the optional checksum when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  img [0:255];
    logic [7:0]  run_xor;
    logic [31:0] wa [$];
    logic [31:0] wd [$];

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    // Record every write the memory would see.
    always @(posedge clk) begin
        if (!rst && mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        run_xor  = run_xor ^ b;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Ends the load: checksum byte when enabled, else just the WRITE cycle.
    task automatic finish_load(input logic [7:0] x);
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(x);
`else
        if (x === 8'hxx) $display("unused");
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, mem_we, busy, done, err, cpu_hold} !== 6'b000001 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: rdy/we/busy/done/err/hold=%b addr=%h wdata=%h required 000001 0 0",
                     {in_ready, mem_we, busy, done, err, cpu_hold}, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h02;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ignores_valid: rdy=%b busy=%b hold=%b required 0 0 1", in_ready, busy, cpu_hold);
        end
    endtask

    task automatic test_nominal();
        wa.delete(); wd.delete();
        img[0] = 8'h14; img[1] = 8'h00; img[2] = 8'h08; img[3] = 8'h21;
        img[4] = 8'h14; img[5] = 8'h00; img[6] = 8'h10; img[7] = 8'h42;
        pulse_start();
        send_byte(8'd2);
        run_xor = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h14000821) begin
            miscompares++;
            $display("FAIL nominal_w0: we=%b addr=%h data=%h required 1 00000000 14000821", mem_we, mem_addr, mem_wdata);
        end
        for (int i = 4; i < 8; i++) send_byte(img[i]);
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h14001042) begin
            miscompares++;
            $display("FAIL nominal_w1: we=%b addr=%h data=%h required 1 00000004 14001042", mem_we, mem_addr, mem_wdata);
        end
        finish_load(8'h7B);
        vectors++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL nominal_done: done=%b hold=%b busy=%b we=%b required 1 0 0 0", done, cpu_hold, busy, mem_we);
        end
        vectors++;
        if (wa.size() !== 2) begin
            miscompares++;
            $display("FAIL nominal_count: writes=%0d required 2", wa.size());
        end
    endtask

    task automatic test_backpressure();
        wa.delete(); wd.delete();
        pulse_start();
        vectors++;
        if (cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_hold: hold=%b done=%b busy=%b required 1 0 1", cpu_hold, done, busy);
        end
        send_byte(8'd2);
        run_xor = 8'h00;
        send_byte(8'h14);
        send_byte(8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || wa.size() !== 0) begin
            miscompares++;
            $display("FAIL stall_state: busy=%b rdy=%b writes=%0d required 1 1 0", busy, in_ready, wa.size());
        end
        send_byte(8'h08);
        send_byte(8'h21);
        send_byte(8'h14);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h42);
        finish_load(8'h7B);
        vectors++;
        if (wa.size() !== 2 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_count: writes=%0d done=%b required 2 1", wa.size(), done);
        end else begin
            vectors++;
            if (wa[0] !== 32'h0 || wd[0] !== 32'h14000821 || wa[1] !== 32'h4 || wd[1] !== 32'h14001042) begin
                miscompares++;
                $display("FAIL bp_words: %h:%h %h:%h required 0:14000821 4:14001042", wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_bad_len();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'd0);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_err: err=%b busy=%b hold=%b done=%b required 1 0 1 0", err, busy, cpu_hold, done);
        end
        in_valid = 1'b1; in_data = 8'h05;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || in_ready !== 1'b0 || wa.size() !== 0) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b rdy=%b writes=%0d required 1 0 0", err, in_ready, wa.size());
        end
        pulse_start();
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL err_cleared: err=%b busy=%b required 0 1", err, busy);
        end
        send_byte(8'd65);
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || cpu_hold !== 1'b1 || wa.size() !== 0) begin
            miscompares++;
            $display("FAIL len65_err: err=%b hold=%b writes=%0d required 1 1 0", err, cpu_hold, wa.size());
        end
    endtask

    task automatic test_full_depth();
        int bad;
        wa.delete(); wd.delete();
        for (int i = 0; i < 256; i++) img[i] = 8'(i);
        pulse_start();
        send_byte(8'd64);
        run_xor = 8'h00;
        for (int i = 0; i < 256; i++) send_byte(img[i]);
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 32'hFC || mem_wdata !== 32'hFCFDFEFF) begin
            miscompares++;
            $display("FAIL full_last: we=%b addr=%h data=%h required 1 000000fc fcfdfeff", mem_we, mem_addr, mem_wdata);
        end
        finish_load(8'h00);
        repeat (4) @(negedge clk);
        vectors++;
        if (wa.size() !== 64 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL full_count: writes=%0d done=%b required 64 1", wa.size(), done);
        end else begin
            bad = 0;
            for (int i = 0; i < 64; i++) begin
                if (wa[i] !== 32'(i * 4) ||
                    wd[i] !== {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}) bad++;
            end
            vectors++;
            if (bad !== 0) begin
                miscompares++;
                $display("FAIL full_words: bad_entries=%0d required 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'd3);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        vectors++;
        if (wa.size() !== 1 || wd[0] !== 32'h11223344) begin
            miscompares++;
            $display("FAIL mid_first_word: writes=%0d required 1 with 11223344", wa.size());
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, mem_we, busy, done, err, cpu_hold} !== 6'b000001 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: rdy/we/busy/done/err/hold=%b addr=%h wdata=%h required 000001 0 0",
                     {in_ready, mem_we, busy, done, err, cpu_hold}, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        pulse_start();
        send_byte(8'd1);
        run_xor = 8'h00;
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'hA1B2C3D4) begin
            miscompares++;
            $display("FAIL reload_word: we=%b addr=%h data=%h required 1 0 a1b2c3d4", mem_we, mem_addr, mem_wdata);
        end
        finish_load(8'h04);
        vectors++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || wa.size() !== 1) begin
            miscompares++;
            $display("FAIL reload_done: done=%b hold=%b writes=%0d required 1 0 1", done, cpu_hold, wa.size());
        end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        pulse_start();
        send_byte(8'd1);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
        send_byte(8'h00);
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL csum_match: done=%b err=%b hold=%b required 1 0 0", done, err, cpu_hold);
        end
        pulse_start();
        send_byte(8'd1);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
        send_byte(8'h01);
        vectors++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL csum_mismatch: err=%b done=%b hold=%b required 1 0 1", err, done, cpu_hold);
        end
    endtask
`endif

    initial begin
        run_xor = 8'h00;
        test_reset();
        test_nominal();
        test_backpressure();
        test_bad_len();
        test_full_depth();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
